// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and index helper for the slot arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COOL
    } arb_state_t;

    // Explicit wrap so N need not be a power of two.
    function automatic int wrap_inc(input int i, input int n);
        return (i >= n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request at or after the pointer, with wrap
module rr_pick #(
    parameter int N  = 3,
    parameter int OW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] ptr,
    output logic          valid,
    output logic [OW-1:0] idx
);

    always_comb begin
        int j;
        valid = |req;
        idx   = '0;
        j     = 0;
        // Scan farthest-first so the nearest set bit from ptr is the last write.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) idx = OW'(j);
        end
    end

endmodule

// File: rtl/rr_slot_arbiter.sv
// rtl/rr_slot_arbiter.sv - round-robin single-owner arbiter with hold budget and cool-down
module rr_slot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout
);

    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
    localparam logic [N-1:0]  ONE      = N'(1);

    arb_state_t    state;
    logic [OW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          pick_valid;
    logic [OW-1:0] pick_idx;
    logic          owner_done;
    logic          owner_gone;
    logic          budget_hit;

    rr_pick #(
        .N  (N),
        .OW (OW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Priority: done beats withdrawal beats budget, so timeout fires only on a pure budget release.
    always_comb begin
        owner_done = done[owner];
        owner_gone = !req[owner];
        budget_hit = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (pick_valid) begin
                        state <= GRANT;
                        owner <= pick_idx;
                        cnt   <= '0;
                        gnt   <= ONE << pick_idx;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (owner_done || owner_gone || budget_hit) begin
                        state   <= COOL;
                        gnt     <= '0;
                        ptr     <= OW'(wrap_inc(int'(owner), N));
                        timeout <= !owner_done && !owner_gone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COOL: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// tb/tb_rr_slot_arbiter.sv - directed self-checking bench for rr_slot_arbiter
module tb_rr_slot_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] gnt;
    logic         busy;
    logic [1:0]   owner;
    logic         timeout;

    int checks   = 0;
    int failures = 0;

    rr_slot_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .owner   (owner),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        done  = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 3'b111;
        tick();
        tick();
        checks++;
        if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 3'b001) begin failures++; $display("FAIL reset_first_gnt got=%b exp=001", gnt); end
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b010;
        tick();
        checks++;
        if (gnt !== 3'b010) begin failures++; $display("FAIL single_gnt1 got=%b exp=010", gnt); end
        checks++;
        if (owner !== 2'd1) begin failures++; $display("FAIL single_owner got=%0d exp=1", owner); end
        tick();
        tick();
        done = 3'b010;
        tick();
        done = '0;
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b1) begin
            failures++; $display("FAIL single_release got gnt=%b busy=%b exp gnt=000 busy=1", gnt, busy);
        end
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL single_no_timeout got=%b exp=0", timeout); end
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 3'b000) begin
            failures++; $display("FAIL single_idle got gnt=%b busy=%b exp gnt=000 busy=0", gnt, busy);
        end
        tick();
        checks++;
        if (gnt !== 3'b010) begin failures++; $display("FAIL single_regrant got=%b exp=010", gnt); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] order [4];
        order[0] = 3'b001;
        order[1] = 3'b010;
        order[2] = 3'b100;
        order[3] = 3'b001;
        do_reset();
        req = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gnt !== order[i]) begin failures++; $display("FAIL fair_gnt%0d got=%b exp=%b", i, gnt, order[i]); end
            done = order[i];
            tick();
            done = '0;
            checks++;
            if (gnt !== 3'b000) begin failures++; $display("FAIL fair_gap_a%0d got=%b exp=000", i, gnt); end
            tick();
            checks++;
            if (gnt !== 3'b000) begin failures++; $display("FAIL fair_gap_b%0d got=%b exp=000", i, gnt); end
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 3'b100;
        tick();
        for (int i = 0; i < MAX_HOLD; i++) begin
            checks++;
            if (gnt !== 3'b100 || timeout !== 1'b0) begin
                failures++; $display("FAIL to_hold%0d got gnt=%b to=%b exp gnt=100 to=0", i, gnt, timeout);
            end
            tick();
        end
        checks++;
        if (gnt !== 3'b000 || timeout !== 1'b1) begin
            failures++; $display("FAIL to_pulse got gnt=%b to=%b exp gnt=000 to=1", gnt, timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_len got=%b exp=0", timeout); end
        tick();
        checks++;
        if (gnt !== 3'b100) begin failures++; $display("FAIL to_regrant got=%b exp=100", gnt); end
        tick();
        tick();
        tick();
        done = 3'b100;
        tick();
        done = '0;
        checks++;
        if (gnt !== 3'b000 || timeout !== 1'b0) begin
            failures++; $display("FAIL to_done_last got gnt=%b to=%b exp gnt=000 to=0", gnt, timeout);
        end
        tick();
        tick();
        tick();
        tick();
        tick();
        req = 3'b000;
        tick();
        checks++;
        if (gnt !== 3'b000 || timeout !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL to_withdraw_last got gnt=%b to=%b busy=%b exp 000/0/1", gnt, timeout, busy);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 3'b111;
        tick();
        done = 3'b010;
        tick();
        done = '0;
        checks++;
        if (gnt !== 3'b001 || busy !== 1'b1) begin
            failures++; $display("FAIL wd_foreign_done got gnt=%b busy=%b exp gnt=001 busy=1", gnt, busy);
        end
        req = 3'b110;
        tick();
        checks++;
        if (gnt !== 3'b000 || timeout !== 1'b0) begin
            failures++; $display("FAIL wd_release got gnt=%b to=%b exp gnt=000 to=0", gnt, timeout);
        end
        req = 3'b101;
        tick();
        tick();
        checks++;
        if (gnt !== 3'b100) begin failures++; $display("FAIL wd_ptr_advance got=%b exp=100", gnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b010;
        tick();
        checks++;
        if (gnt !== 3'b010) begin failures++; $display("FAIL rm_pre got=%b exp=010", gnt); end
        reset = 1'b0;
        tick();
        checks++;
        if (gnt !== 3'b000 || owner !== 2'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL rm_cleared got gnt=%b owner=%0d busy=%b exp 000/0/0", gnt, owner, busy);
        end
        reset = 1'b1;
        req   = 3'b011;
        tick();
        checks++;
        if (gnt !== 3'b001) begin failures++; $display("FAIL rm_first got=%b exp=001", gnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
